kbd_lcd_line_editor: RTL and testbench



---
 rtl/kbd_lcd_pkg.sv | 26 ++
 rtl/kbd_lcd_line_editor_byte_fifo.sv | 49 ++++
 rtl/kbd_lcd_line_editor.sv | 165 ++++++++++++++++
 tb/tb_kbd_lcd_line_editor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_lcd_pkg.sv
// Shared constants, FSM encoding and the cursor-to-DDRAM address map for the
// keyboard-to-LCD line editor.
package kbd_lcd_pkg;

  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_SP    = 8'h20;
  localparam logic [7:0] ASC_TILDE = 8'h7E;

  localparam logic [6:0] LINE2_BASE = 7'h40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SEND,
    ST_CLEAR
  } edState_e;

  // Linear position 0-31 -> DDRAM address (line 2 starts at 0x40).
  function automatic logic [6:0] lcdAddrOf(input logic [4:0] pos);
    logic [6:0] col;
    col = {3'b000, pos[3:0]};
    return pos[4] ? (LINE2_BASE | col) : col;
  endfunction

endpackage

// File: rtl/kbd_lcd_line_editor_byte_fifo.sv
// Small synchronous byte FIFO; pushes while full are rejected even if a pop
// happens in the same cycle.
module byte_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  logic          doPush, doPop;

  assign full_o  = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign dout_o  = mem[rdPtr_q];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/kbd_lcd_line_editor.sv
// Line editor between the PS/2 keyboard interface and the 16x2 LCD driver:
// buffers ASCII bytes, tracks the cursor and issues handshaked cell writes.
module kbd_lcd_line_editor
  import kbd_lcd_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] CLR_CHAR   = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_ascii,
  input  logic       rx_data_ready,
  input  logic       rx_released,
  output logic       rx_read,
  output logic       lcd_valid,
  output logic [6:0] lcd_addr,
  output logic [7:0] lcd_char,
  input  logic       lcd_ack,
  output logic [4:0] cursor,
  output logic       fifo_overflow
);

  logic       armFlag_q, rxRead_q, overflow_q;
  logic       capture, fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [7:0] fifoDout;

  edState_e   state_q, state_d;
  logic [7:0] byte_q, byte_d, char_q, char_d;
  logic [6:0] addr_q, addr_d;
  logic [4:0] cursor_q, cursor_d, target_q, target_d, enterTarget;
  logic [3:0] clrCnt_q, clrCnt_d;
  logic       valid_q, valid_d, incPost_q, incPost_d;

  // Level-sensitive ready: one capture per assertion, re-armed once it drops.
  assign capture  = rx_data_ready && armFlag_q;
  assign fifoPush = capture && !rx_released && !fifoFull;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armFlag_q  <= 1'b1;
      rxRead_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (capture)             armFlag_q <= 1'b0;
      else if (!rx_data_ready) armFlag_q <= 1'b1;
      rxRead_q <= capture;
      if (capture && !rx_released && fifoFull) overflow_q <= 1'b1;
    end
  end

  byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .din_i   (rx_ascii),
    .dout_o  (fifoDout),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign enterTarget = (cursor_q < 5'd16) ? 5'd16 : 5'd0;

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    char_d    = char_q;
    addr_d    = addr_q;
    cursor_d  = cursor_q;
    target_d  = target_q;
    clrCnt_d  = clrCnt_q;
    valid_d   = valid_q;
    incPost_d = incPost_q;
    fifoPop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          byte_d  = fifoDout;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (byte_q >= ASC_SP && byte_q <= ASC_TILDE) begin
          addr_d    = lcdAddrOf(cursor_q);
          char_d    = byte_q;
          incPost_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = ST_SEND;
        end else if (byte_q == ASC_BS) begin
          if (cursor_q != 5'd0) begin
            cursor_d  = cursor_q - 5'd1;
            addr_d    = lcdAddrOf(cursor_q - 5'd1);
            char_d    = CLR_CHAR;
            incPost_d = 1'b0;
            valid_d   = 1'b1;
            state_d   = ST_SEND;
          end
        end else if (byte_q == ASC_CR) begin
          cursor_d = enterTarget;
          target_d = enterTarget;
          clrCnt_d = 4'd0;
          addr_d   = lcdAddrOf(enterTarget);
          char_d   = CLR_CHAR;
          valid_d  = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_SEND: begin
        if (lcd_ack) begin
          valid_d = 1'b0;
          if (incPost_q) cursor_d = cursor_q + 5'd1;
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Alternate request and idle cycles so each erase is a separate handshake.
        if (valid_q) begin
          if (lcd_ack) begin
            valid_d = 1'b0;
            if (clrCnt_q == 4'd15) state_d = ST_IDLE;
            else                   clrCnt_d = clrCnt_q + 4'd1;
          end
        end else begin
          valid_d = 1'b1;
          addr_d  = lcdAddrOf(target_q + {1'b0, clrCnt_q});
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      byte_q    <= 8'h00;
      char_q    <= 8'h00;
      addr_q    <= 7'h00;
      cursor_q  <= 5'd0;
      target_q  <= 5'd0;
      clrCnt_q  <= 4'd0;
      valid_q   <= 1'b0;
      incPost_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      char_q    <= char_d;
      addr_q    <= addr_d;
      cursor_q  <= cursor_d;
      target_q  <= target_d;
      clrCnt_q  <= clrCnt_d;
      valid_q   <= valid_d;
      incPost_q <= incPost_d;
    end
  end

  assign rx_read       = rxRead_q;
  assign lcd_valid     = valid_q;
  assign lcd_addr      = addr_q;
  assign lcd_char      = char_q;
  assign cursor        = cursor_q;
  assign fifo_overflow = overflow_q;

endmodule

// File: tb/tb_kbd_lcd_line_editor.sv
// Directed self-checking bench for kbd_lcd_line_editor; a negedge monitor logs
// every accepted LCD write and the checks compare against hand-computed values.
module tb_kbd_lcd_line_editor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_ascii = 8'h00;
  logic       rx_data_ready = 1'b0;
  logic       rx_released = 1'b0;
  logic       rx_read;
  logic       lcd_valid;
  logic [6:0] lcd_addr;
  logic [7:0] lcd_char;
  logic       lcd_ack = 1'b1;
  logic [4:0] cursor;
  logic       fifo_overflow;

  int checks = 0;
  int errors = 0;
  int rxReadCount = 0;
  int gapViol = 0;
  int heldChange = 0;
  logic [6:0] wrAddr [$];
  logic [7:0] wrChar [$];
  logic       prevAccept = 1'b0;
  logic       prevHeld = 1'b0;
  logic [6:0] heldAddr = '0;
  logic [7:0] heldChar = '0;

  kbd_lcd_line_editor #(.FIFO_DEPTH(8), .CLR_CHAR(8'h20)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_ascii      (rx_ascii),
    .rx_data_ready (rx_data_ready),
    .rx_released   (rx_released),
    .rx_read       (rx_read),
    .lcd_valid     (lcd_valid),
    .lcd_addr      (lcd_addr),
    .lcd_char      (lcd_char),
    .lcd_ack       (lcd_ack),
    .cursor        (cursor),
    .fifo_overflow (fifo_overflow)
  );

  always #5 clk = ~clk;

  // Log accepted writes, rx_read pulses, missing valid gaps and unstable held requests.
  always @(negedge clk) begin
    if (rx_read) rxReadCount++;
    if (prevAccept && lcd_valid) gapViol++;
    if (prevHeld && lcd_valid && (lcd_addr != heldAddr || lcd_char != heldChar)) heldChange++;
    if (lcd_valid && lcd_ack) begin
      wrAddr.push_back(lcd_addr);
      wrChar.push_back(lcd_char);
    end
    prevAccept = lcd_valid && lcd_ack;
    prevHeld   = lcd_valid && !lcd_ack;
    heldAddr   = lcd_addr;
    heldChar   = lcd_char;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    waitCycles(2);
    wrAddr.delete();
    wrChar.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] ascii, input logic released);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    rx_ascii      = ascii;
    rx_released   = released;
    rx_data_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rx_read) seen = 1'b1;
    end
    if (!seen) checkOutput("rxReadTimeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rx_data_ready = 1'b0;
    rx_released   = 1'b0;
  endtask

  initial begin
    int n0;
    bit found;

    reset = 1'b1;
    #12;
    checkOutput("rstValid", lcd_valid, 0);
    checkOutput("rstAddr", lcd_addr, 0);
    checkOutput("rstChar", lcd_char, 0);
    checkOutput("rstCursor", cursor, 0);
    checkOutput("rstOverflow", fifo_overflow, 0);
    checkOutput("rstRxRead", rx_read, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    waitCycles(2);

    // Single 'A' then its release code.
    applyStimulus(8'h41, 1'b0);
    waitCycles(8);
    checkOutput("aRxReads", rxReadCount, 1);
    checkOutput("aWrites", wrAddr.size(), 1);
    if (wrAddr.size() >= 1) begin
      checkOutput("aAddr", wrAddr[0], 7'h00);
      checkOutput("aChar", wrChar[0], 8'h41);
    end
    checkOutput("aCursor", cursor, 1);
    applyStimulus(8'h41, 1'b1);
    waitCycles(8);
    checkOutput("relRxReads", rxReadCount, 2);
    checkOutput("relWrites", wrAddr.size(), 1);

    // 17 chars then up to 32 with cursor wrap.
    pulseReset();
    for (int i = 0; i < 17; i++) applyStimulus(8'h61 + 8'(i), 1'b0);
    waitCycles(10);
    checkOutput("w17Cursor", cursor, 17);
    checkOutput("w17Writes", wrAddr.size(), 17);
    for (int i = 17; i < 32; i++) applyStimulus(8'h41 + 8'(i), 1'b0);
    waitCycles(10);
    checkOutput("w32Writes", wrAddr.size(), 32);
    if (wrAddr.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        checkOutput($sformatf("w32Addr%0d", i), wrAddr[i], (i < 16) ? i : 32'h40 + i - 16);
        checkOutput($sformatf("w32Char%0d", i), wrChar[i], (i < 17) ? 32'h61 + i : 32'h41 + i);
      end
    end
    checkOutput("w32Cursor", cursor, 0);

    // Backspace at cursor 3 and at cursor 0.
    pulseReset();
    applyStimulus(8'h78, 1'b0);
    applyStimulus(8'h79, 1'b0);
    applyStimulus(8'h7A, 1'b0);
    waitCycles(10);
    wrAddr.delete();
    wrChar.delete();
    applyStimulus(8'h08, 1'b0);
    waitCycles(8);
    checkOutput("bsWrites", wrAddr.size(), 1);
    if (wrAddr.size() >= 1) begin
      checkOutput("bsAddr", wrAddr[0], 7'h02);
      checkOutput("bsChar", wrChar[0], 8'h20);
    end
    checkOutput("bsCursor", cursor, 2);
    pulseReset();
    applyStimulus(8'h08, 1'b0);
    waitCycles(8);
    checkOutput("bs0Writes", wrAddr.size(), 0);
    checkOutput("bs0Cursor", cursor, 0);

    // Enter from cursor 5 clears line 2, second enter clears line 1.
    pulseReset();
    for (int i = 0; i < 5; i++) applyStimulus(8'h30 + 8'(i), 1'b0);
    waitCycles(10);
    wrAddr.delete();
    wrChar.delete();
    applyStimulus(8'h0D, 1'b0);
    waitCycles(50);
    checkOutput("cr1Writes", wrAddr.size(), 16);
    if (wrAddr.size() == 16)
      for (int k = 0; k < 16; k++) begin
        checkOutput($sformatf("cr1Addr%0d", k), wrAddr[k], 32'h40 + k);
        checkOutput($sformatf("cr1Char%0d", k), wrChar[k], 8'h20);
      end
    checkOutput("cr1Cursor", cursor, 16);
    wrAddr.delete();
    wrChar.delete();
    applyStimulus(8'h0D, 1'b0);
    waitCycles(50);
    checkOutput("cr2Writes", wrAddr.size(), 16);
    if (wrAddr.size() == 16)
      for (int k = 0; k < 16; k++) checkOutput($sformatf("cr2Addr%0d", k), wrAddr[k], k);
    checkOutput("cr2Cursor", cursor, 0);

    // Backpressure: 10 bytes with ack low overflow the 8-entry FIFO by one.
    pulseReset();
    lcd_ack = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(8'h41 + 8'(i), 1'b0);
    waitCycles(4);
    checkOutput("bpValid", lcd_valid, 1);
    checkOutput("bpAddr", lcd_addr, 7'h00);
    checkOutput("bpChar", lcd_char, 8'h41);
    checkOutput("bpOverflow", fifo_overflow, 1);
    checkOutput("bpHeldStable", heldChange, 0);
    @(posedge clk); #1;
    lcd_ack = 1'b1;
    waitCycles(60);
    checkOutput("bpWrites", wrAddr.size(), 9);
    if (wrAddr.size() == 9)
      for (int i = 0; i < 9; i++) begin
        checkOutput($sformatf("bpAddr%0d", i), wrAddr[i], i);
        checkOutput($sformatf("bpChar%0d", i), wrChar[i], 32'h41 + i);
      end
    checkOutput("bpCursor", cursor, 9);

    // Reset in the middle of a clear sequence (k=7 outstanding).
    pulseReset();
    checkOutput("postRstOverflow", fifo_overflow, 0);
    applyStimulus(8'h0D, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (wrAddr.size() == 7 && lcd_valid) found = 1'b1;
    end
    checkOutput("clrK7Reached", found, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstValid", lcd_valid, 0);
    checkOutput("midRstCursor", cursor, 0);
    n0 = wrAddr.size();
    @(posedge clk); #1;
    reset = 1'b0;
    waitCycles(40);
    checkOutput("midRstWrites", n0, 7);
    checkOutput("midRstNoMore", wrAddr.size(), 7);
    checkOutput("midRstIdle", lcd_valid, 0);

    checkOutput("validGaps", gapViol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: got 0x0 expected 0x1");
    $fatal(1, "[TB] timeout");
  end

endmodule
